// File: rtl/mmio_port_responder_if.sv
// ---------------------------------------------------------------------------
// mmio_port_responder_if
// Processor-side load/store handshake for the MMIO port responder.
//   Address   : byte address from the processor data path
//   WriteData : store data
//   MemWrite  : store request, level, held until Ready
//   MemRead   : load request, level, held until Ready
//   ReadData  : load data, valid only in the Ready cycle, 0 otherwise
//   Ready     : single-cycle access-complete strobe
// master = processor side, slave = responder side.
// ---------------------------------------------------------------------------
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Ready;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, Ready
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, Ready
    );
endinterface

// File: rtl/mmio_port_responder.sv
// ---------------------------------------------------------------------------
// mmio_port_responder
// Memory-mapped 8-bit input / 32-bit output port with a wait-stated
// request/ready handshake. Four word registers in a 16-byte window:
//   0x0 PORT_OUT (RW), 0x4 PORT_IN (RO, synced pins),
//   0x8 STATUS (RO edge flags, write-1-to-clear), 0xC CTRL (RW, edge mask).
// Ports:
//   clk     : sole clock, rising edge
//   reset   : asynchronous, active-low reset
//   bus     : slave side of mmio_port_responder_if
//   PortIn  : asynchronous external input pins (8)
//   PortOut : registered output port (32)
//   Irq     : level interrupt request
// Optional feature macro: PORTIN_EDGE_IRQ_EN -- rising-edge detection on the
// synced PortIn bits into STATUS and a masked, registered Irq. Without it,
// STATUS reads 0, CTRL is plain storage and Irq is tied 0.
// ---------------------------------------------------------------------------
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    mmio_port_responder_if.slave        bus,
    input  logic [7:0]                  PortIn,
    output logic [31:0]                 PortOut,
    output logic                        Irq
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] port_out_q;
    logic [7:0]  ctrl_q;
    logic [7:0]  sync1_q;
    logic [7:0]  sync2_q;
    logic [7:0]  status_rd;
    logic        hit;
    logic        req;

    assign req = bus.MemRead | bus.MemWrite;
    assign hit = (bus.Address[31:4] == BASE_ADDR[31:4]) && req;

    function automatic logic [31:0] reg_read(
        input logic [1:0]  off,
        input logic [31:0] pout,
        input logic [7:0]  pin,
        input logic [7:0]  st,
        input logic [7:0]  ct
    );
        case (off)
            2'd0:    reg_read = pout;
            2'd1:    reg_read = {24'b0, pin};
            2'd2:    reg_read = {24'b0, st};
            default: reg_read = {24'b0, ct};
        endcase
    endfunction

    // Ready and ReadData are loaded on the edge entering ACK so both are
    // plain flops and fall back to 0 on the edge leaving ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            port_out_q <= '0;
            ctrl_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            sync1_q <= PortIn;
            sync2_q <= sync1_q;
            ready_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        off_q   <= bus.Address[3:2];
                        wdata_q <= bus.WriteData;
                        // Simultaneous read+write is treated as a write.
                        wr_q    <= bus.MemWrite;
                        cnt_q   <= WS;
                        if (WS == 4'd0) begin
                            state_q <= S_ACK;
                            ready_q <= 1'b1;
                            if (!bus.MemWrite)
                                rdata_q <= reg_read(bus.Address[3:2], port_out_q,
                                                    sync2_q, status_rd, ctrl_q);
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        // Requester gave up: drop without side effects.
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= S_ACK;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        if (!wr_q)
                            rdata_q <= reg_read(off_q, port_out_q, sync2_q,
                                                status_rd, ctrl_q);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    if (wr_q) begin
                        case (off_q)
                            2'd0:    port_out_q <= wdata_q;
                            2'd3:    ctrl_q     <= wdata_q[7:0];
                            default: ;  // PORT_IN ignored, STATUS cleared below
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PORTIN_EDGE_IRQ_EN
    logic [7:0] prev_q;
    logic [7:0] status_q;
    logic [7:0] status_d;
    logic [7:0] status_clr;
    logic       irq_q;

    // A new edge wins over a same-cycle write-1-to-clear of that bit.
    always_comb begin
        status_clr = '0;
        if (state_q == S_ACK && wr_q && off_q == 2'd2)
            status_clr = wdata_q[7:0];
        status_d = (status_q & ~status_clr) | (sync2_q & ~prev_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= sync2_q;
            status_q <= status_d;
            irq_q    <= |(status_d & ctrl_q);
        end
    end

    assign status_rd = status_q;
    assign Irq       = irq_q;
`else
    assign status_rd = '0;
    assign Irq       = 1'b0;
`endif

    assign bus.Ready    = ready_q;
    assign bus.ReadData = rdata_q;
    assign PortOut      = port_out_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
module tb_mmio_port_responder;

`ifdef PORTIN_EDGE_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  pin;
  logic [31:0] pout1, pout3;
  logic        irq1, irq3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  int          lat;
  int          rdy_cnt;

  mmio_port_responder_if b1 ();
  mmio_port_responder_if b3 ();

  mmio_port_responder #(.BASE_ADDR(32'hFFFF0000), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(rst_n), .bus(b1), .PortIn(pin), .PortOut(pout1), .Irq(irq1)
  );

  mmio_port_responder #(.BASE_ADDR(32'hFFFF0000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst_n), .bus(b3), .PortIn(pin), .PortOut(pout3), .Irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w);
    if (sel) begin
      b3.Address = a; b3.WriteData = d; b3.MemRead = r; b3.MemWrite = w;
    end else begin
      b1.Address = a; b1.WriteData = d; b1.MemRead = r; b1.MemWrite = w;
    end
  endtask

  task automatic acc(input bit sel, input logic [31:0] a, input logic [31:0] d,
                     input logic r, input logic w,
                     output logic [31:0] rdata, output int latency);
    drive(sel, a, d, r, w);
    latency = -1;
    rdata   = '0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      if (sel ? b3.Ready : b1.Ready) begin
        latency = int'(i);
        rdata   = sel ? b3.ReadData : b1.ReadData;
        break;
      end
    end
    drive(sel, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pin   = 8'h00;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    tick();
    tick();

    check("rst_ready", b1.Ready, 1'b0);
    check("rst_rdata", b1.ReadData, 32'h0);
    check("rst_portout", pout1, 32'h0);
    check("rst_irq", irq1, 1'b0);
    rst_n = 1'b1;
    tick();

    acc(1'b0, 32'hFFFF0000, 32'hA5A5_0001, 1'b0, 1'b1, rd, lat);
    check("store_latency", lat, 2);
    check("store_rdata_zero", rd, 32'h0);
    tick();
    check("store_portout", pout1, 32'hA5A5_0001);
    check("ready_single_cycle", b1.Ready, 1'b0);

    acc(1'b0, 32'hFFFF0003, '0, 1'b1, 1'b0, rd, lat);
    check("load_portout_lat", lat, 2);
    check("load_portout", rd, 32'hA5A5_0001);
    tick();

    pin = 8'h3C;
    tick(); tick(); tick();
    acc(1'b0, 32'hFFFF0004, '0, 1'b1, 1'b0, rd, lat);
    check("load_portin", rd, 32'h0000_003C);
    tick();

    acc(1'b0, 32'hFFFF0004, 32'hFFFF_FFFF, 1'b0, 1'b1, rd, lat);
    check("store_portin_ready", lat, 2);
    tick();
    acc(1'b0, 32'hFFFF0004, '0, 1'b1, 1'b0, rd, lat);
    check("portin_unchanged", rd, 32'h0000_003C);
    tick();

    acc(1'b0, 32'hFFFF000C, 32'h1234_5681, 1'b0, 1'b1, rd, lat);
    tick();
    acc(1'b0, 32'hFFFF000C, '0, 1'b1, 1'b0, rd, lat);
    check("ctrl_readback", rd, 32'h0000_0081);
    tick();

    acc(1'b0, 32'hFFFE0000, '0, 1'b1, 1'b0, rd, lat);
    check("miss_no_ready", lat, -1);
    tick();

    acc(1'b0, 32'hFFFF0000, 32'h0BAD_F00D, 1'b1, 1'b1, rd, lat);
    check("rw_latency", lat, 2);
    check("rw_rdata_zero", rd, 32'h0);
    tick();
    check("rw_portout", pout1, 32'h0BAD_F00D);

    acc(1'b0, 32'hFFFF0008, 32'h0000_00FF, 1'b0, 1'b1, rd, lat);
    tick();
    acc(1'b0, 32'hFFFF000C, 32'h0000_0001, 1'b0, 1'b1, rd, lat);
    tick();
    acc(1'b0, 32'hFFFF0008, '0, 1'b1, 1'b0, rd, lat);
    check("status_cleared", rd, 32'h0);
    tick();
    check("irq_idle", irq1, 1'b0);
    pin = 8'h3D;
    tick(); tick(); tick(); tick();
    check("irq_on_edge", irq1, EDGE);
    acc(1'b0, 32'hFFFF0008, '0, 1'b1, 1'b0, rd, lat);
    check("status_edge", rd, EDGE ? 32'h0000_0001 : 32'h0);
    tick();
    acc(1'b0, 32'hFFFF0008, 32'h0000_0001, 1'b0, 1'b1, rd, lat);
    tick();
    check("irq_after_w1c", irq1, 1'b0);
    acc(1'b0, 32'hFFFF0008, '0, 1'b1, 1'b0, rd, lat);
    check("status_after_w1c", rd, 32'h0);
    tick();

    acc(1'b1, 32'hFFFF0000, 32'h0000_0011, 1'b0, 1'b1, rd, lat);
    check("ws3_store_latency", lat, 4);
    tick();
    check("ws3_portout", pout3, 32'h0000_0011);
    drive(1'b1, 32'hFFFF0000, 32'h0000_0022, 1'b0, 1'b1);
    tick();
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    rdy_cnt = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      if (b3.Ready) rdy_cnt++;
    end
    check("abort_no_ready", rdy_cnt, 0);
    check("abort_no_write", pout3, 32'h0000_0011);
    acc(1'b1, 32'hFFFF0000, '0, 1'b1, 1'b0, rd, lat);
    check("after_abort_lat", lat, 4);
    check("after_abort_rdata", rd, 32'h0000_0011);
    tick();

    drive(1'b1, 32'hFFFF0000, 32'h0000_0033, 1'b0, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_portout3", pout3, 32'h0);
    check("midrst_ready3", b3.Ready, 1'b0);
    check("midrst_portout1", pout1, 32'h0);
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    rdy_cnt = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      if (b3.Ready) rdy_cnt++;
    end
    check("midrst_no_ready", rdy_cnt, 0);
    check("midrst_no_write", pout3, 32'h0);
    acc(1'b1, 32'hFFFF0000, 32'h0000_0044, 1'b0, 1'b1, rd, lat);
    check("post_rst_lat", lat, 4);
    tick();
    check("post_rst_portout", pout3, 32'h0000_0044);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
